// File: rtl/sdr_init_ref_ctl_if.sv
// Command-bus bundle between the init/refresh sequencer and the main SDRAM
// controller: refresh handshake, bus ownership and the command pins.
interface sdr_init_ref_ctl_if;
  logic        ref_req;
  logic        ref_gnt;
  logic        own_bus;
  logic        cmd_cke;
  logic        cmd_cs_n;
  logic        cmd_ras_n;
  logic        cmd_cas_n;
  logic        cmd_we_n;
  logic [1:0]  cmd_ba;
  logic [12:0] cmd_addr;

  modport master (
    output ref_req, own_bus, cmd_cke, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n,
           cmd_ba, cmd_addr,
    input  ref_gnt
  );

  modport slave (
    input  ref_req, own_bus, cmd_cke, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n,
           cmd_ba, cmd_addr,
    output ref_gnt
  );
endinterface

// File: rtl/sdr_init_ref_ctl.sv
// SDRAM power-up initialisation and periodic auto-refresh sequencer.
// Runs NOP wait, PRECHARGE ALL, NUM_INIT_REF auto refreshes and LOAD MODE,
// then counts refresh periods and borrows the command bus from the main
// controller (req/gnt) to issue the owed refreshes.
module sdr_init_ref_ctl #(
  parameter int INIT_WAIT    = 10000,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 8,
  parameter int T_MRD        = 2,
  parameter int NUM_INIT_REF = 2,
  parameter int REF_INTERVAL = 1560,
  parameter int MAX_PEND     = 7
) (
  input  logic                sdram_clk,
  input  logic                sdram_reset,
  input  logic [12:0]         cfg_mode_reg,
  output logic                init_done,
  output logic                ref_overflow,
  sdr_init_ref_ctl_if.master  bus
);

  localparam int TW = $clog2(INIT_WAIT + T_RP + T_RFC + T_MRD + 1);
  localparam int CW = (NUM_INIT_REF > 1) ? $clog2(NUM_INIT_REF) : 1;
  localparam int RW = $clog2(REF_INTERVAL + 1);
  localparam int PW = $clog2(MAX_PEND + 1);

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AR    = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_INIT_PRE,
    S_INIT_TRP,
    S_INIT_AR,
    S_INIT_TRFC,
    S_INIT_MRS,
    S_INIT_TMRD,
    S_IDLE,
    S_REQ,
    S_REF_PRE,
    S_REF_TRP,
    S_REF_AR,
    S_REF_TRFC
  } state_t;

  state_t         state, state_nx;
  logic [TW-1:0]  timer, timer_nx;
  logic [CW-1:0]  init_ref_cnt, init_ref_nx;
  logic [RW-1:0]  ref_timer;
  logic [PW-1:0]  pend, pend_nx;
  logic           cke_q;
  logic           ref_wrap;
  logic           pend_dec;
  logic           overflow_set;
  logic [3:0]     cmd_code;

  assign init_done    = (state inside {S_IDLE, S_REQ, S_REF_PRE, S_REF_TRP, S_REF_AR, S_REF_TRFC});
  assign bus.own_bus  = !(state inside {S_IDLE, S_REQ});
  assign bus.ref_req  = (state == S_REQ);
  assign ref_wrap     = init_done && (ref_timer == RW'(REF_INTERVAL - 1));
  assign pend_dec     = (state == S_REF_AR);

  // Pending-refresh bookkeeping: a wrap and an AR in the same cycle cancel out,
  // and a wrap that finds the counter already full is a lost refresh.
  always_comb begin
    pend_nx      = pend;
    overflow_set = 1'b0;
    if (ref_wrap && !pend_dec) begin
      if (pend != PW'(MAX_PEND)) begin
        pend_nx = pend + PW'(1);
      end else begin
        overflow_set = 1'b1;
      end
    end else if (!ref_wrap && pend_dec) begin
      pend_nx = pend - PW'(1);
    end
  end

  // Next-state logic; command states count from their own cycle so a timing
  // value of 1 goes straight to the next command without a wait state.
  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    init_ref_nx = init_ref_cnt;
    case (state)
      S_INIT_WAIT: begin
        if (cke_q) begin
          if (timer == TW'(INIT_WAIT - 1)) begin
            state_nx = S_INIT_PRE;
            timer_nx = '0;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
      end
      S_INIT_PRE, S_INIT_TRP: begin
        if (timer == TW'(T_RP - 1)) begin
          state_nx    = S_INIT_AR;
          timer_nx    = '0;
          init_ref_nx = '0;
        end else begin
          state_nx = S_INIT_TRP;
          timer_nx = timer + TW'(1);
        end
      end
      S_INIT_AR, S_INIT_TRFC: begin
        if (timer == TW'(T_RFC - 1)) begin
          timer_nx = '0;
          if (init_ref_cnt == CW'(NUM_INIT_REF - 1)) begin
            state_nx = S_INIT_MRS;
          end else begin
            state_nx    = S_INIT_AR;
            init_ref_nx = init_ref_cnt + CW'(1);
          end
        end else begin
          state_nx = S_INIT_TRFC;
          timer_nx = timer + TW'(1);
        end
      end
      S_INIT_MRS, S_INIT_TMRD: begin
        if (timer == TW'(T_MRD - 1)) begin
          state_nx = S_IDLE;
          timer_nx = '0;
        end else begin
          state_nx = S_INIT_TMRD;
          timer_nx = timer + TW'(1);
        end
      end
      S_IDLE: begin
        timer_nx = '0;
        if (pend_nx != '0) begin
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        timer_nx = '0;
        if (bus.ref_gnt) begin
          state_nx = S_REF_PRE;
        end
      end
      S_REF_PRE, S_REF_TRP: begin
        if (timer == TW'(T_RP - 1)) begin
          state_nx = S_REF_AR;
          timer_nx = '0;
        end else begin
          state_nx = S_REF_TRP;
          timer_nx = timer + TW'(1);
        end
      end
      S_REF_AR, S_REF_TRFC: begin
        if (timer == TW'(T_RFC - 1)) begin
          timer_nx = '0;
          state_nx = (pend_nx != '0) ? S_REF_AR : S_IDLE;
        end else begin
          state_nx = S_REF_TRFC;
          timer_nx = timer + TW'(1);
        end
      end
      default: begin
        state_nx = S_INIT_WAIT;
        timer_nx = '0;
      end
    endcase
  end

  // Sequencer state, cycle timer and init refresh count.
  always_ff @(posedge sdram_clk or posedge sdram_reset) begin
    if (sdram_reset) begin
      state        <= S_INIT_WAIT;
      timer        <= '0;
      init_ref_cnt <= '0;
      cke_q        <= 1'b0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      init_ref_cnt <= init_ref_nx;
      cke_q        <= 1'b1;
    end
  end

  // Refresh period timer, pending counter and sticky overflow flag.
  always_ff @(posedge sdram_clk or posedge sdram_reset) begin
    if (sdram_reset) begin
      ref_timer    <= '0;
      pend         <= '0;
      ref_overflow <= 1'b0;
    end else begin
      if (!init_done || ref_wrap) begin
        ref_timer <= '0;
      end else begin
        ref_timer <= ref_timer + RW'(1);
      end
      pend <= pend_nx;
      if (overflow_set) begin
        ref_overflow <= 1'b1;
      end
    end
  end

  // Command decode: one-cycle commands from the command states, NOP filler
  // while this block owns the bus, DESEL otherwise and before cke rises.
  always_comb begin
    cmd_code     = CMD_DESEL;
    bus.cmd_ba   = 2'b00;
    bus.cmd_addr = 13'h0000;
    if (cke_q && bus.own_bus) begin
      cmd_code = CMD_NOP;
      case (state)
        S_INIT_PRE, S_REF_PRE: begin
          cmd_code     = CMD_PRE;
          bus.cmd_addr = 13'h0400;
        end
        S_INIT_AR, S_REF_AR: begin
          cmd_code = CMD_AR;
        end
        S_INIT_MRS: begin
          cmd_code     = CMD_MRS;
          bus.cmd_addr = cfg_mode_reg;
        end
        default: begin
          cmd_code = CMD_NOP;
        end
      endcase
    end
  end

  assign bus.cmd_cke   = cke_q;
  assign bus.cmd_cs_n  = cmd_code[3];
  assign bus.cmd_ras_n = cmd_code[2];
  assign bus.cmd_cas_n = cmd_code[1];
  assign bus.cmd_we_n  = cmd_code[0];

endmodule

// File: tb/tb_sdr_init_ref_ctl.sv
// Self-checking bench for sdr_init_ref_ctl: a monitor logs every issued
// command with its cycle number; each scenario queues the commands it expects
// and compares them against the log.
module tb_sdr_init_ref_ctl;

  localparam int INIT_WAIT    = 10;
  localparam int T_RP         = 2;
  localparam int T_RFC        = 4;
  localparam int T_MRD        = 2;
  localparam int NUM_INIT_REF = 2;
  localparam int REF_INTERVAL = 50;
  localparam int MAX_PEND     = 3;
  localparam int DONE_CYC     = INIT_WAIT + T_RP + NUM_INIT_REF * T_RFC + T_MRD;

  localparam logic [3:0] C_DESEL = 4'b1111;
  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_AR    = 4'b0001;
  localparam logic [3:0] C_MRS   = 4'b0000;

  typedef struct packed {
    int          cyc;
    logic [3:0]  code;
    logic [12:0] addr;
  } cmd_ev_t;

  logic        sdram_clk = 1'b0;
  logic        sdram_reset = 1'b1;
  logic [12:0] cfg_mode_reg = 13'h0000;
  logic        init_done;
  logic        ref_overflow;
  int          cyc = -1;
  int          n_cmp = 0;
  int          n_bad = 0;
  cmd_ev_t     exp_q[$];
  cmd_ev_t     obs_q[$];
  logic [3:0]  bus_code;

  sdr_init_ref_ctl_if bus_if ();

  sdr_init_ref_ctl #(
    .INIT_WAIT(INIT_WAIT), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD),
    .NUM_INIT_REF(NUM_INIT_REF), .REF_INTERVAL(REF_INTERVAL), .MAX_PEND(MAX_PEND)
  ) dut (
    .sdram_clk(sdram_clk),
    .sdram_reset(sdram_reset),
    .cfg_mode_reg(cfg_mode_reg),
    .init_done(init_done),
    .ref_overflow(ref_overflow),
    .bus(bus_if.master)
  );

  always #5 sdram_clk = ~sdram_clk;

  assign bus_code = {bus_if.cmd_cs_n, bus_if.cmd_ras_n, bus_if.cmd_cas_n, bus_if.cmd_we_n};

  // Cycle numbering: 0 is the first rising edge after reset release.
  always @(posedge sdram_clk or posedge sdram_reset) begin
    if (sdram_reset) cyc <= -1;
    else             cyc <= cyc + 1;
  end

  // Log every real command (anything other than NOP/DESEL) with its cycle.
  always @(negedge sdram_clk) begin
    cmd_ev_t ev;
    if (!sdram_reset && cyc >= 0 && bus_code != C_NOP && bus_code != C_DESEL) begin
      ev.cyc  = cyc;
      ev.code = bus_code;
      ev.addr = bus_if.cmd_addr;
      obs_q.push_back(ev);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_ev(input int c, input logic [3:0] code, input logic [12:0] addr);
    cmd_ev_t ev;
    ev.cyc  = c;
    ev.code = code;
    ev.addr = addr;
    exp_q.push_back(ev);
  endtask

  task automatic push_init_expect(input logic [12:0] mode);
    int t;
    t = INIT_WAIT;
    push_ev(t, C_PRE, 13'h0400);
    t += T_RP;
    for (int k = 0; k < NUM_INIT_REF; k++) begin
      push_ev(t, C_AR, 13'h0000);
      t += T_RFC;
    end
    push_ev(t, C_MRS, mode);
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 5000) begin
      @(negedge sdram_clk);
      guard++;
    end
    if (cyc != n) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
    end
  endtask

  task automatic release_reset(input logic [12:0] mode);
    @(negedge sdram_clk);
    sdram_reset  = 1'b1;
    bus_if.ref_gnt = 1'b0;
    cfg_mode_reg = mode;
    @(negedge sdram_clk);
    @(negedge sdram_clk);
    obs_q.delete();
    exp_q.delete();
    sdram_reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge sdram_clk);
    sdram_reset = 1'b1;
    #1;
    n_cmp++;
    if (bus_if.cmd_cke !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_cke: got %b, expected 0", bus_if.cmd_cke);
    end
    n_cmp++;
    if (bus_code !== C_DESEL) begin
      n_bad++;
      $display("[TB] FAIL reset_cmd: got %b, expected %b", bus_code, C_DESEL);
    end
    n_cmp++;
    if ({bus_if.cmd_ba, bus_if.cmd_addr} !== 15'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_ba_addr: got %h/%h, expected 0/0", bus_if.cmd_ba, bus_if.cmd_addr);
    end
    n_cmp++;
    if ({bus_if.own_bus, init_done, bus_if.ref_req, ref_overflow} !== 4'b1000) begin
      n_bad++;
      $display("[TB] FAIL reset_flags: got own/done/req/ovf=%b, expected 1000",
               {bus_if.own_bus, init_done, bus_if.ref_req, ref_overflow});
    end
  endtask

  task automatic test_init();
    cmd_ev_t e, o;
    release_reset(13'h0033);
    push_init_expect(13'h0033);
    wait_cyc(0);
    n_cmp++;
    if ({bus_if.cmd_cke, bus_code} !== {1'b1, C_NOP}) begin
      n_bad++;
      $display("[TB] FAIL init_c0: got cke/cmd=%b/%b, expected 1/%b", bus_if.cmd_cke, bus_code, C_NOP);
    end
    wait_cyc(DONE_CYC - 1);
    n_cmp++;
    if ({init_done, bus_if.own_bus} !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL init_before_done: got done/own=%b, expected 01", {init_done, bus_if.own_bus});
    end
    wait_cyc(DONE_CYC);
    n_cmp++;
    if ({init_done, bus_if.own_bus, bus_code} !== {2'b10, C_DESEL}) begin
      n_bad++;
      $display("[TB] FAIL init_done: got done/own/cmd=%b/%b/%b, expected 1/0/%b",
               init_done, bus_if.own_bus, bus_code, C_DESEL);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL init_cmd: got nothing, expected cyc=%0d cmd=%b addr=%h", e.cyc, e.code, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("[TB] FAIL init_cmd: got cyc=%0d cmd=%b addr=%h, expected cyc=%0d cmd=%b addr=%h",
                   o.cyc, o.code, o.addr, e.cyc, e.code, e.addr);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL init_extra: got %0d unexpected commands, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_gnt_idle();
    wait_cyc(DONE_CYC + 8);
    bus_if.ref_gnt = 1'b1;
    wait_cyc(DONE_CYC + 9);
    bus_if.ref_gnt = 1'b0;
    wait_cyc(DONE_CYC + 11);
    n_cmp++;
    if ({bus_if.own_bus, bus_code} !== {1'b0, C_DESEL}) begin
      n_bad++;
      $display("[TB] FAIL gnt_idle_bus: got own/cmd=%b/%b, expected 0/%b", bus_if.own_bus, bus_code, C_DESEL);
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL gnt_idle_cmds: got %0d commands, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_single_ref();
    cmd_ev_t e, o;
    int w, rel;
    w   = DONE_CYC + REF_INTERVAL;
    rel = w + 1 + T_RP + T_RFC;
    bus_if.ref_gnt = 1'b1;
    push_ev(w + 1, C_PRE, 13'h0400);
    push_ev(w + 1 + T_RP, C_AR, 13'h0000);
    wait_cyc(w - 1);
    n_cmp++;
    if (bus_if.ref_req !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL single_req_early: got %b, expected 0", bus_if.ref_req);
    end
    wait_cyc(w);
    n_cmp++;
    if ({bus_if.ref_req, bus_if.own_bus} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL single_req: got req/own=%b, expected 10", {bus_if.ref_req, bus_if.own_bus});
    end
    wait_cyc(w + 1);
    n_cmp++;
    if ({bus_if.ref_req, bus_if.own_bus} !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL single_grant: got req/own=%b, expected 01", {bus_if.ref_req, bus_if.own_bus});
    end
    wait_cyc(rel - 1);
    n_cmp++;
    if (bus_if.own_bus !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL single_hold: got own=%b, expected 1", bus_if.own_bus);
    end
    wait_cyc(rel);
    n_cmp++;
    if ({bus_if.own_bus, bus_code} !== {1'b0, C_DESEL}) begin
      n_bad++;
      $display("[TB] FAIL single_release: got own/cmd=%b/%b, expected 0/%b", bus_if.own_bus, bus_code, C_DESEL);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL single_cmd: got nothing, expected cyc=%0d cmd=%b addr=%h", e.cyc, e.code, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("[TB] FAIL single_cmd: got cyc=%0d cmd=%b addr=%h, expected cyc=%0d cmd=%b addr=%h",
                   o.cyc, o.code, o.addr, e.cyc, e.code, e.addr);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL single_extra: got %0d unexpected commands, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    cmd_ev_t e, o;
    int g, rel;
    release_reset(13'h0033);
    wait_cyc(DONE_CYC);
    obs_q.delete();
    g   = DONE_CYC + 160;
    rel = g + 1 + T_RP + MAX_PEND * T_RFC;
    wait_cyc(g);
    n_cmp++;
    if ({bus_if.ref_req, ref_overflow, bus_if.own_bus} !== 3'b100) begin
      n_bad++;
      $display("[TB] FAIL b2b_waiting: got req/ovf/own=%b, expected 100",
               {bus_if.ref_req, ref_overflow, bus_if.own_bus});
    end
    bus_if.ref_gnt = 1'b1;
    push_ev(g + 1, C_PRE, 13'h0400);
    for (int k = 0; k < MAX_PEND; k++) push_ev(g + 1 + T_RP + k * T_RFC, C_AR, 13'h0000);
    wait_cyc(rel - 1);
    n_cmp++;
    if (bus_if.own_bus !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL b2b_hold: got own=%b, expected 1", bus_if.own_bus);
    end
    wait_cyc(rel);
    n_cmp++;
    if ({bus_if.own_bus, ref_overflow} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL b2b_release: got own/ovf=%b, expected 00", {bus_if.own_bus, ref_overflow});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL b2b_cmd: got nothing, expected cyc=%0d cmd=%b addr=%h", e.cyc, e.code, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("[TB] FAIL b2b_cmd: got cyc=%0d cmd=%b addr=%h, expected cyc=%0d cmd=%b addr=%h",
                   o.cyc, o.code, o.addr, e.cyc, e.code, e.addr);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL b2b_extra: got %0d unexpected commands, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_overflow();
    cmd_ev_t e, o;
    int ov, g, rel;
    release_reset(13'h0033);
    wait_cyc(DONE_CYC);
    obs_q.delete();
    ov  = DONE_CYC + (MAX_PEND + 1) * REF_INTERVAL;
    g   = DONE_CYC + 210;
    rel = g + 1 + T_RP + MAX_PEND * T_RFC;
    wait_cyc(ov - 1);
    n_cmp++;
    if (ref_overflow !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL ovf_early: got %b, expected 0", ref_overflow);
    end
    wait_cyc(ov);
    n_cmp++;
    if (ref_overflow !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL ovf_set: got %b, expected 1", ref_overflow);
    end
    wait_cyc(g);
    n_cmp++;
    if ({ref_overflow, bus_if.ref_req} !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL ovf_hold: got ovf/req=%b, expected 11", {ref_overflow, bus_if.ref_req});
    end
    bus_if.ref_gnt = 1'b1;
    push_ev(g + 1, C_PRE, 13'h0400);
    for (int k = 0; k < MAX_PEND; k++) push_ev(g + 1 + T_RP + k * T_RFC, C_AR, 13'h0000);
    wait_cyc(rel);
    n_cmp++;
    if ({bus_if.own_bus, ref_overflow} !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL ovf_release: got own/ovf=%b, expected 01", {bus_if.own_bus, ref_overflow});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL ovf_cmd: got nothing, expected cyc=%0d cmd=%b addr=%h", e.cyc, e.code, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("[TB] FAIL ovf_cmd: got cyc=%0d cmd=%b addr=%h, expected cyc=%0d cmd=%b addr=%h",
                   o.cyc, o.code, o.addr, e.cyc, e.code, e.addr);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL ovf_extra: got %0d unexpected commands, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_trfc();
    cmd_ev_t e, o;
    int w, ar;
    w  = DONE_CYC + 5 * REF_INTERVAL;
    ar = w + 1 + T_RP;
    push_ev(w + 1, C_PRE, 13'h0400);
    push_ev(ar, C_AR, 13'h0000);
    wait_cyc(ar + 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL midref_cmd: got nothing, expected cyc=%0d cmd=%b addr=%h", e.cyc, e.code, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("[TB] FAIL midref_cmd: got cyc=%0d cmd=%b addr=%h, expected cyc=%0d cmd=%b addr=%h",
                   o.cyc, o.code, o.addr, e.cyc, e.code, e.addr);
        end
      end
    end
    sdram_reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus_if.cmd_cke, bus_code} !== {1'b0, C_DESEL}) begin
      n_bad++;
      $display("[TB] FAIL midref_reset_cmd: got cke/cmd=%b/%b, expected 0/%b", bus_if.cmd_cke, bus_code, C_DESEL);
    end
    n_cmp++;
    if ({bus_if.own_bus, init_done, bus_if.ref_req, ref_overflow} !== 4'b1000) begin
      n_bad++;
      $display("[TB] FAIL midref_reset_flags: got own/done/req/ovf=%b, expected 1000",
               {bus_if.own_bus, init_done, bus_if.ref_req, ref_overflow});
    end
    release_reset(13'h0155);
    push_init_expect(13'h0155);
    wait_cyc(DONE_CYC);
    n_cmp++;
    if ({init_done, bus_if.own_bus} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL replay_done: got done/own=%b, expected 10", {init_done, bus_if.own_bus});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL replay_cmd: got nothing, expected cyc=%0d cmd=%b addr=%h", e.cyc, e.code, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("[TB] FAIL replay_cmd: got cyc=%0d cmd=%b addr=%h, expected cyc=%0d cmd=%b addr=%h",
                   o.cyc, o.code, o.addr, e.cyc, e.code, e.addr);
        end
      end
    end
  endtask

  initial begin
    bus_if.ref_gnt = 1'b0;
    $display("[TB] starting sdr_init_ref_ctl bench");
    test_reset();
    test_init();
    test_gnt_idle();
    test_single_ref();
    test_back_to_back();
    test_overflow();
    test_reset_mid_trfc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
